// File: rtl/bel_fft_avl_mif.sv
// -----------------------------------------------------------------------------
// bel_fft_avl_mif
//
// Avalon-MM master bridge for the FFT core's internal master bus. A level-held
// internal read or write request is turned into exactly one Avalon transfer.
// The bridge honours avm_waitrequest and, for reads, waits for the pipelined
// avm_readdatavalid. Only one transaction is ever in flight.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   adr_i/dat_i/bsel_i  internal request address, write data, byte selects
//   wr_i/rd_i           internal write/read request (level, held until done)
//   dat_o               last captured read data (registered)
//   ack_o               one-cycle completion pulse
//   err_o               one-cycle abort pulse (watchdog timeout)
//   avm_*               Avalon-MM master side; address/writedata/byteenable
//                       and read/write strobes are all registered
//
// Configuration
//   BEL_FFT_AVL_MIF_TIMEOUT_EN  when defined, an 8-bit watchdog aborts any
//                               transaction still busy after TIMEOUT cycles
//                               and pulses err_o. When undefined, the bridge
//                               waits indefinitely and err_o is tied to 0.
// -----------------------------------------------------------------------------
module bel_fft_avl_mif #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int BCNT    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [AWIDTH-1:0] adr_i,
   input  logic [DWIDTH-1:0] dat_i,
   output logic [DWIDTH-1:0] dat_o,
   input  logic [BCNT-1:0]   bsel_i,
   input  logic              wr_i,
   input  logic              rd_i,
   output logic              ack_o,
   output logic              err_o,
   output logic [AWIDTH-1:0] avm_address,
   output logic [DWIDTH-1:0] avm_writedata,
   output logic [BCNT-1:0]   avm_byteenable,
   output logic              avm_read,
   output logic              avm_write,
   input  logic              avm_waitrequest,
   input  logic [DWIDTH-1:0] avm_readdata,
   input  logic              avm_readdatavalid
);

   // The watchdog counter is 8 bits wide, so the limit must fit in 1..255.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
      $error("bel_fft_avl_mif: TIMEOUT must be in 1..255");
   end

   typedef enum logic [2:0] {IDLE, WR, RD, RDV, ACK} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] adr_q, adr_d;
   logic [DWIDTH-1:0] wdat_q, wdat_d;
   logic [BCNT-1:0]   be_q, be_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              ack_q, ack_d;
   logic [DWIDTH-1:0] dat_q, dat_d;

`ifdef BEL_FFT_AVL_MIF_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

   logic       err_q, err_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cnt_inc;
   logic       busy;
`endif

   // Next-state logic. ACK is a dead cycle in which requests are not sampled,
   // so a request that is still held while ack_o is high is not reissued.
   // avm_readdatavalid is only looked at in RD/RDV; elsewhere it is stale.
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      be_d    = be_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      ack_d   = 1'b0;
      dat_d   = dat_q;

      case (state_q)
         IDLE: begin
            // Write has priority when both requests are raised together.
            if (wr_i) begin
               adr_d   = adr_i;
               wdat_d  = dat_i;
               be_d    = bsel_i;
               wr_d    = 1'b1;
               state_d = WR;
            end else if (rd_i) begin
               adr_d   = adr_i;
               be_d    = bsel_i;
               rd_d    = 1'b1;
               state_d = RD;
            end
         end
         WR: begin
            if (!avm_waitrequest) begin
               wr_d    = 1'b0;
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         RD: begin
            if (!avm_waitrequest) begin
               rd_d = 1'b0;
               // A zero-latency slave returns data in the accept cycle.
               if (avm_readdatavalid) begin
                  dat_d   = avm_readdata;
                  ack_d   = 1'b1;
                  state_d = ACK;
               end else begin
                  state_d = RDV;
               end
            end
         end
         RDV: begin
            if (avm_readdatavalid) begin
               dat_d   = avm_readdata;
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef BEL_FFT_AVL_MIF_TIMEOUT_EN
      // Watchdog: the count is held at zero in IDLE so it starts from zero on
      // entry to WR/RD. A completion in the limit cycle wins over the abort,
      // which is why the abort is gated by ack_d.
      busy    = (state_q == WR) || (state_q == RD) || (state_q == RDV);
      cnt_inc = cnt_q + 8'd1;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = 8'd0;
      end else if (busy) begin
         cnt_d = cnt_inc;
      end
      if (busy && !ack_d && (cnt_inc == TIMEOUT_LIM)) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         err_d   = 1'b1;
         state_d = ACK;
      end
`endif
   end

   // State and output registers; reset clears every output immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         adr_q   <= '0;
         wdat_q  <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
`ifdef BEL_FFT_AVL_MIF_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
`ifdef BEL_FFT_AVL_MIF_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign avm_address    = adr_q;
   assign avm_writedata  = wdat_q;
   assign avm_byteenable = be_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign ack_o          = ack_q;
   assign dat_o          = dat_q;

`ifdef BEL_FFT_AVL_MIF_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bel_fft_avl_mif.sv
// -----------------------------------------------------------------------------
// tb_bel_fft_avl_mif
//
// Bench for the Avalon-MM master bridge. Each transaction is described by a
// record (request kind, request fields, slave stall length, read latency,
// read data, idle gap) plus its expected ack cycle and resulting dat_o.
// Cycle-by-cycle expectations are derived from those transaction-level
// numbers. Hand-written sequences cover reset in the middle of a read and,
// when the watchdog is built in, the timeout abort.
// -----------------------------------------------------------------------------
module tb_bel_fft_avl_mif;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BC = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic [AW-1:0] adr_i;
   logic [DW-1:0] dat_i;
   logic [DW-1:0] dat_o;
   logic [BC-1:0] bsel_i;
   logic          wr_i;
   logic          rd_i;
   logic          ack_o;
   logic          err_o;
   logic [AW-1:0] avm_address;
   logic [DW-1:0] avm_writedata;
   logic [BC-1:0] avm_byteenable;
   logic          avm_read;
   logic          avm_write;
   logic          avm_waitrequest;
   logic [DW-1:0] avm_readdata;
   logic          avm_readdatavalid;

   // Free-running clock, period 10.
   always #5 clk_i = ~clk_i;

   bel_fft_avl_mif #(
      .AWIDTH (AW),
      .DWIDTH (DW),
      .BCNT   (BC),
      .TIMEOUT(8)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .adr_i            (adr_i),
      .dat_i            (dat_i),
      .dat_o            (dat_o),
      .bsel_i           (bsel_i),
      .wr_i             (wr_i),
      .rd_i             (rd_i),
      .ack_o            (ack_o),
      .err_o            (err_o),
      .avm_address      (avm_address),
      .avm_writedata    (avm_writedata),
      .avm_byteenable   (avm_byteenable),
      .avm_read         (avm_read),
      .avm_write        (avm_write),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid)
   );

   typedef enum int {K_WR, K_RD, K_BOTH} kind_t;

   typedef struct {
      kind_t         kind;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [BC-1:0] bsel;
      int            stall;
      int            lat;
      logic [DW-1:0] rdata;
      int            gap;
      int            exp_ack;
      logic [DW-1:0] exp_dat;
   } vec_t;

   // Expected outputs for the current cycle.
   logic [AW-1:0] e_adr  = '0;
   logic [DW-1:0] e_wdat = '0;
   logic [BC-1:0] e_be   = '0;
   logic          e_rd   = 1'b0;
   logic          e_wr   = 1'b0;
   logic          e_ack  = 1'b0;
   logic          e_err  = 1'b0;
   logic [DW-1:0] e_dat  = '0;

   int nvec = 0;
   int nerr = 0;

   vec_t vecs[$];

   function automatic vec_t mkVec(input kind_t kind, input logic [AW-1:0] adr,
                                  input logic [DW-1:0] dat, input logic [BC-1:0] bsel,
                                  input int stall, input int lat, input logic [DW-1:0] rdata,
                                  input int gap, input int exp_ack, input logic [DW-1:0] exp_dat);
      vec_t v;
      v.kind    = kind;
      v.adr     = adr;
      v.dat     = dat;
      v.bsel    = bsel;
      v.stall   = stall;
      v.lat     = lat;
      v.rdata   = rdata;
      v.gap     = gap;
      v.exp_ack = exp_ack;
      v.exp_dat = exp_dat;
      return v;
   endfunction

   // Compare every DUT output against the current expectation.
   task automatic checkOutput(input string name);
      nvec++;
      if (avm_address !== e_adr || avm_writedata !== e_wdat || avm_byteenable !== e_be ||
          avm_read !== e_rd || avm_write !== e_wr || ack_o !== e_ack || err_o !== e_err ||
          dat_o !== e_dat) begin
         nerr++;
         $display("[TB] FAIL %s @%0t: got adr=%h wdat=%h be=%h rd=%b wr=%b ack=%b err=%b dat=%h; required adr=%h wdat=%h be=%h rd=%b wr=%b ack=%b err=%b dat=%h",
                  name, $time, avm_address, avm_writedata, avm_byteenable, avm_read, avm_write,
                  ack_o, err_o, dat_o, e_adr, e_wdat, e_be, e_rd, e_wr, e_ack, e_err, e_dat);
      end
   endtask

   // No request; the slave side toggles randomly and must be ignored.
   task automatic driveIdle();
      wr_i              = 1'b0;
      rd_i              = 1'b0;
      adr_i             = $urandom;
      dat_i             = $urandom;
      bsel_i            = 4'($urandom);
      avm_waitrequest   = 1'($urandom_range(0, 1));
      avm_readdatavalid = 1'($urandom_range(0, 1));
      avm_readdata      = $urandom;
   endtask

   // Drive the inputs for cycle c of transaction v (cycle 0 = request seen).
   task automatic applyStimulus(input vec_t v, input int c);
      wr_i = (v.kind != K_RD);
      rd_i = (v.kind != K_WR);
      if (c == 0) begin
         adr_i  = v.adr;
         dat_i  = v.dat;
         bsel_i = v.bsel;
      end else begin
         adr_i  = $urandom;
         dat_i  = $urandom;
         bsel_i = 4'($urandom);
      end
      if (c >= 1 && c <= v.stall) avm_waitrequest = 1'b1;
      else if (c == v.stall + 1)  avm_waitrequest = 1'b0;
      else                        avm_waitrequest = 1'($urandom_range(0, 1));
      if (v.kind == K_RD && c >= 1 && c < v.exp_ack) begin
         avm_readdatavalid = (c == v.stall + 1 + v.lat);
         avm_readdata      = avm_readdatavalid ? v.rdata : $urandom;
      end else begin
         avm_readdatavalid = 1'($urandom_range(0, 1));
         avm_readdata      = $urandom;
      end
   endtask

   // Run one transaction: idle gap, then request held through the ack cycle.
   task automatic runVector(input vec_t v, input string name);
      logic strobe;
      for (int g = 0; g < v.gap; g++) begin
         @(posedge clk_i); #1;
         e_rd  = 1'b0;
         e_wr  = 1'b0;
         e_ack = 1'b0;
         e_err = 1'b0;
         checkOutput({name, " gap"});
         driveIdle();
      end
      for (int c = 0; c <= v.exp_ack; c++) begin
         @(posedge clk_i); #1;
         strobe = (c >= 1) && (c <= v.stall + 1);
         e_wr   = strobe && (v.kind != K_RD);
         e_rd   = strobe && (v.kind == K_RD);
         if (c == 1) begin
            e_adr = v.adr;
            e_be  = v.bsel;
            if (v.kind != K_RD) e_wdat = v.dat;
         end
         e_ack = (c == v.exp_ack);
         e_err = 1'b0;
         if (c == v.exp_ack) e_dat = v.exp_dat;
         checkOutput(name);
         applyStimulus(v, c);
      end
   endtask

   initial begin
      vec_t v;
      logic [DW-1:0] prev;

      // Directed entries, expected ack cycle and dat_o worked out by hand.
      vecs.push_back(mkVec(K_WR,   32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        1, 2, 32'h0));
      vecs.push_back(mkVec(K_WR,   32'h10, 32'hDEADBEEF, 4'hF, 3, 0, 32'h0,        1, 5, 32'h0));
      vecs.push_back(mkVec(K_RD,   32'h40, 32'h0,        4'hF, 0, 3, 32'h12345678, 0, 5, 32'h12345678));
      vecs.push_back(mkVec(K_RD,   32'h44, 32'h0,        4'h3, 0, 0, 32'hA5A5A5A5, 0, 2, 32'hA5A5A5A5));
      vecs.push_back(mkVec(K_BOTH, 32'h48, 32'h0BADF00D, 4'h5, 1, 2, 32'hFFFFFFFF, 0, 3, 32'hA5A5A5A5));
      vecs.push_back(mkVec(K_RD,   32'h4C, 32'h0,        4'h8, 2, 1, 32'h00C0FFEE, 2, 5, 32'h00C0FFEE));

      // Random entries: a write acks two cycles after the stall ends; a read
      // acks one cycle after its data arrives, lat cycles after acceptance.
      for (int i = 0; i < 80; i++) begin
         prev      = vecs[vecs.size() - 1].exp_dat;
         v.kind    = kind_t'(int'($urandom_range(0, 2)));
         v.adr     = $urandom;
         v.dat     = $urandom;
         v.bsel    = 4'($urandom);
         v.stall   = int'($urandom_range(0, 3));
         v.lat     = int'($urandom_range(0, 3));
         v.rdata   = $urandom;
         v.gap     = int'($urandom_range(0, 2));
         v.exp_ack = (v.kind == K_RD) ? v.stall + 2 + v.lat : v.stall + 2;
         v.exp_dat = (v.kind == K_RD) ? v.rdata : prev;
         vecs.push_back(v);
      end

      // Reset: all outputs zero while reset is held.
      driveIdle();
      #1 rst_i = 1'b1;
      #2 checkOutput("reset");
      @(posedge clk_i); #1;
      checkOutput("reset held");
      @(negedge clk_i);
      rst_i = 1'b0;

      foreach (vecs[i]) begin
         runVector(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while waiting for read data: strobes and data drop at once.
      @(posedge clk_i); #1;
      e_rd = 1'b0; e_wr = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      checkOutput("rstmid idle");
      wr_i = 1'b0; rd_i = 1'b1; adr_i = 32'h80; bsel_i = 4'hF;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      @(posedge clk_i); #1;
      e_rd = 1'b1; e_adr = 32'h80; e_be = 4'hF;
      checkOutput("rstmid read");
      adr_i = $urandom;
      @(posedge clk_i); #1;
      e_rd = 1'b0;
      checkOutput("rstmid wait");
      #2 rst_i = 1'b1;
      #1;
      e_adr = '0; e_wdat = '0; e_be = '0; e_dat = '0;
      checkOutput("rstmid async");
      rd_i = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("rstmid held");
      @(negedge clk_i);
      rst_i = 1'b0;
      runVector(mkVec(K_WR, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 0, 2, 32'h0), "rstmid write");

`ifdef BEL_FFT_AVL_MIF_TIMEOUT_EN
      // Watchdog with TIMEOUT=8: read stuck in waitrequest is held for 8
      // cycles, then err_o pulses once; a late readdatavalid is ignored.
      @(posedge clk_i); #1;
      e_rd = 1'b0; e_wr = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      checkOutput("tmo idle");
      wr_i = 1'b0; rd_i = 1'b1; adr_i = 32'h44; bsel_i = 4'hC;
      avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk_i); #1;
         e_rd  = (c <= 8);
         if (c == 1) begin
            e_adr = 32'h44;
            e_be  = 4'hC;
         end
         e_err = (c == 9);
         e_ack = 1'b0;
         checkOutput($sformatf("tmo c%0d", c));
         rd_i              = (c <= 9);
         avm_waitrequest   = 1'b1;
         avm_readdatavalid = (c == 11);
         avm_readdata      = 32'hBAD0BAD0;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
